// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_pkg
// Purpose : Shared constants for the program counter: datapath word width,
//           next-PC source select encodings and the 11-bit offset
//           sign-extension helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package pc_pkg;

  localparam int WORD_W = 16;

  // Next-PC source select encodings
  localparam logic [1:0] PC_INC   = 2'b00;  // PC + 1 or PC + PC_Label
  localparam logic [1:0] PC_JMP11 = 2'b01;  // PC + sext(label11)
  localparam logic [1:0] PC_REG   = 2'b10;  // Rd_Rm
  localparam logic [1:0] PC_HOLD  = 2'b11;  // PC

  // Replicate bit 10 into the upper five bits.
  function automatic logic [WORD_W-1:0] sext11(input logic [10:0] v);
    return {{(WORD_W-11){v[10]}}, v};
  endfunction

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_if.sv
`default_nettype none
// ============================================================================
// Module  : pc_if
// Purpose : Control/data bundle between the control unit and the program
//           counter.
// Ports   : CE           - register load enable
//           PC_sel       - next-PC source select
//           one_or_label - increment operand select (PC_sel = 00)
//           PC_Label     - 16-bit signed branch offset
//           label11      - 11-bit signed jump offset
//           Rd_Rm        - register-indirect jump target
//           PC_out       - current PC value
//           master modport: control-unit side; slave modport: PC side.
// Revision: 1.0 - initial release
// ============================================================================
interface pc_if;
  import pc_pkg::*;

  logic              CE;
  logic [1:0]        PC_sel;
  logic              one_or_label;
  logic [WORD_W-1:0] PC_Label;
  logic [10:0]       label11;
  logic [WORD_W-1:0] Rd_Rm;
  logic [WORD_W-1:0] PC_out;

  modport master (
    output CE, PC_sel, one_or_label, PC_Label, label11, Rd_Rm,
    input  PC_out
  );

  modport slave (
    input  CE, PC_sel, one_or_label, PC_Label, label11, Rd_Rm,
    output PC_out
  );

endinterface : pc_if
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// ============================================================================
// Module  : pc_next_mux
// Purpose : Combinational next-PC generator. Selects the adder operand
//           (1, PC_Label or sext(label11)), adds it to the current PC modulo
//           2^16, and picks the final source among sum, Rd_Rm and hold.
// Ports   : pc           - current PC value
//           pc_sel       - next-PC source select
//           one_or_label - 0: +1, 1: +pc_label (only for pc_sel = PC_INC)
//           pc_label     - 16-bit signed offset
//           label11      - 11-bit signed offset
//           rd_rm        - register-indirect target
//           next_pc      - selected next PC value
// Revision: 1.0 - initial release
// ============================================================================
module pc_next_mux
  import pc_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic [1:0]        pc_sel,
  input  logic              one_or_label,
  input  logic [WORD_W-1:0] pc_label,
  input  logic [10:0]       label11,
  input  logic [WORD_W-1:0] rd_rm,
  output logic [WORD_W-1:0] next_pc
);

  logic [WORD_W-1:0] operand;
  logic [WORD_W-1:0] sum;

  // A single shared adder serves both relative modes; the operand mux picks
  // the offset. For PC_REG/PC_HOLD the operand is a don't-care.
  always_comb begin
    operand = {{(WORD_W-1){1'b0}}, 1'b1};
    if (pc_sel == PC_JMP11) begin
      operand = sext11(label11);
    end else if (one_or_label) begin
      operand = pc_label;
    end
  end

  // Carry out is intentionally dropped: arithmetic wraps modulo 2^16.
  assign sum = pc + operand;

  always_comb begin
    next_pc = pc;
    case (pc_sel)
      PC_INC:   next_pc = sum;
      PC_JMP11: next_pc = sum;
      PC_REG:   next_pc = rd_rm;
      default:  next_pc = pc;
    endcase
  end

endmodule : pc_next_mux
`default_nettype wire

// File: rtl/pc.sv
`default_nettype none
// ============================================================================
// Module  : pc
// Purpose : 16-bit program counter register. Loads the next-PC value from
//           pc_next_mux when CE=1; synchronous active-high reset to 0000
//           takes priority over CE.
// Ports   : clk - rising-edge clock
//           rst - synchronous active-high reset
//           bus - pc_if slave modport (CE, PC_sel, one_or_label, PC_Label,
//                 label11, Rd_Rm in; PC_out out)
// Revision: 1.0 - initial release
// ============================================================================
module pc
  import pc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  pc_if.slave  bus
);

  logic [WORD_W-1:0] pc_reg;
  logic [WORD_W-1:0] next_pc;

  pc_next_mux u_next_mux (
    .pc           (pc_reg),
    .pc_sel       (bus.PC_sel),
    .one_or_label (bus.one_or_label),
    .pc_label     (bus.PC_Label),
    .label11      (bus.label11),
    .rd_rm        (bus.Rd_Rm),
    .next_pc      (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= '0;
    end else if (bus.CE) begin
      pc_reg <= next_pc;
    end
  end

  // Pure register output: no combinational path from any input.
  assign bus.PC_out = pc_reg;

endmodule : pc
`default_nettype wire

// File: tb/tb_pc.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc
// Purpose : Directed self-checking testbench for the program counter.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc;
  import pc_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pc_if bus ();

  pc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check16(input string tag, input logic [15:0] actual,
                         input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge, then settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    rst              = 1'b1;
    bus.CE           = 1'b0;
    bus.PC_sel       = PC_INC;
    bus.one_or_label = 1'b0;
    bus.PC_Label     = 16'h0000;
    bus.label11      = 11'h000;
    bus.Rd_Rm        = 16'h0000;

    // Reset for two edges
    tick();
    tick();
    check16("reset", bus.PC_out, 16'h0000);

    // Released, CE=0: must hold 0000
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check16("ce0_hold", bus.PC_out, 16'h0000);
    end

    // Sequential increment
    bus.CE = 1'b1;
    tick(); check16("inc1", bus.PC_out, 16'h0001);
    tick(); check16("inc2", bus.PC_out, 16'h0002);

    // Conditional offset +2, then -2
    bus.one_or_label = 1'b1;
    bus.PC_Label     = 16'h0002;
    tick(); check16("lbl_p2a", bus.PC_out, 16'h0004);
    tick(); check16("lbl_p2b", bus.PC_out, 16'h0006);
    bus.PC_Label = 16'hFFFE;
    tick(); check16("lbl_m2", bus.PC_out, 16'h0004);

    // 11-bit jump +3, one_or_label irrelevant
    bus.PC_sel       = PC_JMP11;
    bus.label11      = 11'b000_0000_0011;
    bus.one_or_label = 1'b0;
    tick(); check16("j11_p3a", bus.PC_out, 16'h0007);
    bus.one_or_label = 1'b1;
    tick(); check16("j11_p3b", bus.PC_out, 16'h000A);
    bus.label11 = 11'b111_1111_1101;
    tick(); check16("j11_m3", bus.PC_out, 16'h0007);

    // Register-indirect jump
    bus.PC_sel       = PC_REG;
    bus.Rd_Rm        = 16'h1100;
    bus.one_or_label = 1'b0;
    #1 check16("no_comb_path", bus.PC_out, 16'h0007);
    tick(); check16("reg_ool0", bus.PC_out, 16'h1100);
    bus.one_or_label = 1'b1;
    bus.PC_Label     = 16'h0010;
    tick(); check16("reg_ool1", bus.PC_out, 16'h1100);

    // CE=0 ignores a changed Rd_Rm
    bus.CE    = 1'b0;
    bus.Rd_Rm = 16'hABCD;
    for (int i = 0; i < 3; i++) begin
      tick();
      check16("ce0_reg", bus.PC_out, 16'h1100);
    end

    // Explicit hold select
    bus.CE     = 1'b1;
    bus.PC_sel = PC_HOLD;
    for (int i = 0; i < 4; i++) begin
      bus.one_or_label = i[0];
      tick();
      check16("hold", bus.PC_out, 16'h1100);
    end

    // Upward wrap: FFFF + 1 -> 0000
    bus.PC_sel = PC_REG;
    bus.Rd_Rm  = 16'hFFFF;
    tick(); check16("load_ffff", bus.PC_out, 16'hFFFF);
    bus.PC_sel       = PC_INC;
    bus.one_or_label = 1'b0;
    tick(); check16("wrap_up", bus.PC_out, 16'h0000);

    // Downward wrap: 0000 - 3 -> FFFD, then +8000 -> 7FFD
    bus.PC_sel  = PC_JMP11;
    bus.label11 = 11'h7FD;
    tick(); check16("wrap_down", bus.PC_out, 16'hFFFD);
    bus.PC_sel       = PC_INC;
    bus.one_or_label = 1'b1;
    bus.PC_Label     = 16'h8000;
    tick(); check16("lbl_8000", bus.PC_out, 16'h7FFD);

    // Reset beats a pending register jump
    bus.PC_sel = PC_REG;
    bus.Rd_Rm  = 16'h1234;
    rst        = 1'b1;
    tick(); check16("rst_over_ce", bus.PC_out, 16'h0000);
    rst = 1'b0;
    tick(); check16("after_rst", bus.PC_out, 16'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pc
`default_nettype wire
